// File: rtl/led_activity_sched_if.sv
// Signal bundle between activity-strobe sources and the shared-LED scheduler.
// The master side drives strobes; the slave side (the scheduler) drives LED and status.
interface led_activity_sched_if #(parameter int N = 4);
  logic [N-1:0]       stb;
  logic               led;
  logic               busy;
  logic [$clog2(N):0] cur_id;
  logic [N-1:0]       pending;

  modport master (output stb, input led, busy, cur_id, pending);
  modport slave  (input stb, output led, busy, cur_id, pending);
endinterface

// File: rtl/led_activity_sched.sv
// Round-robin sharing of one status LED between N strobe sources; the granted
// source id is shown as (id+1) flashes followed by a dark gap.
module led_activity_sched #(
  parameter int N          = 4,
  parameter int ON_CYCLES  = 120000,
  parameter int OFF_CYCLES = 120000,
  parameter int GAP_CYCLES = 480000
) (
  input logic                 clk,
  input logic                 rst,
  led_activity_sched_if.slave bus
);
  localparam int IDW  = $clog2(N) + 1;
  localparam int PTRW = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC = (ON_CYCLES > OFF_CYCLES)
                        ? ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES)
                        : ((OFF_CYCLES > GAP_CYCLES) ? OFF_CYCLES : GAP_CYCLES);
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IDW-1:0]  pulses, pulses_n, cur_id, cur_id_n, gid;
  logic [PTRW-1:0] ptr, ptr_n;
  logic [N-1:0]    pending, pending_n, clr, rot;
  logic            led, found;
  int              tmp;

  // Rotate so that bit k of rot is source (ptr+k) mod N; first set bit wins.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    tmp   = 0;
    rot   = N'({pending, pending} >> ptr);
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        tmp   = int'(ptr) + k;
        if (tmp >= N) tmp = tmp - N;
        gid   = IDW'(tmp);
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pulses_n = pulses;
    cur_id_n = cur_id;
    ptr_n    = ptr;
    clr      = '0;
    case (state)
      S_IDLE: if (found) begin
        state_n  = S_ON;
        cur_id_n = gid;
        pulses_n = gid + IDW'(1);
        cnt_n    = CW'(ON_CYCLES - 1);
        clr      = N'(1) << gid;
        if (gid == IDW'(N - 1)) ptr_n = '0;
        else                    ptr_n = PTRW'(gid + IDW'(1));
      end
      S_ON: if (cnt == '0) begin
        if (pulses == IDW'(1)) begin
          state_n = S_GAP;
          cnt_n   = CW'(GAP_CYCLES - 1);
        end else begin
          pulses_n = pulses - IDW'(1);
          state_n  = S_OFF;
          cnt_n    = CW'(OFF_CYCLES - 1);
        end
      end else cnt_n = cnt - CW'(1);
      S_OFF: if (cnt == '0) begin
        state_n = S_ON;
        cnt_n   = CW'(ON_CYCLES - 1);
      end else cnt_n = cnt - CW'(1);
      S_GAP: if (cnt == '0) state_n = S_IDLE;
             else           cnt_n   = cnt - CW'(1);
    endcase
    // A strobe on the grant cycle re-arms the request after clearing it.
    pending_n = (pending & ~clr) | bus.stb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pulses  <= '0;
      cur_id  <= '0;
      ptr     <= '0;
      pending <= '0;
      led     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pulses  <= pulses_n;
      cur_id  <= cur_id_n;
      ptr     <= ptr_n;
      pending <= pending_n;
      led     <= (state_n == S_ON);
    end
  end

  assign bus.led     = led;
  assign bus.busy    = (state != S_IDLE);
  assign bus.cur_id  = cur_id;
  assign bus.pending = pending;
endmodule
